// File: rtl/pe_result_drain_pkg.sv
// Shared sizing helpers for the PE result drain: vector/beat derivation and
// byte addressing into the flat cube result vector.
package pe_result_drain_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned calc_rb(input int unsigned cube_num,
                                           input int unsigned block_num,
                                           input int unsigned array_num);
      return cube_num * block_num * array_num;
   endfunction

   function automatic int unsigned calc_beats(input int unsigned rb,
                                              input int unsigned out_bytes);
      return (rb + out_bytes - 1) / out_bytes;
   endfunction

   // A single-beat vector still needs a 1-bit counter.
   function automatic int unsigned beat_width(input int unsigned beats);
      return (clog2(beats) == 0) ? 1 : clog2(beats);
   endfunction

   // Bit offset of the PE byte (cube, block, array) in the flat result vector.
   function automatic int unsigned byte_index(input int unsigned cube,
                                              input int unsigned block,
                                              input int unsigned array,
                                              input int unsigned array_num,
                                              input int unsigned block_num);
      return 8 * array_num * block_num * cube + 8 * array_num * block + 8 * array;
   endfunction

endpackage

// File: rtl/pe_drain_bank.sv
// One result bank: captures a full cube vector and muxes out one beat,
// zero-filling bytes past the end of the vector.
module pe_drain_bank #(
   parameter int unsigned RB        = 27,
   parameter int unsigned OUT_BYTES = 4,
   parameter int unsigned BW        = 3
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [8*RB-1:0]        din,
   input  logic [BW-1:0]          beat,
   output logic [8*OUT_BYTES-1:0] dout
);

   logic [8*RB-1:0] mem;

   always_ff @(posedge clk) begin
      if (we) mem <= din;
   end

   always_comb begin
      int unsigned idx;
      idx  = 0;
      dout = '0;
      for (int unsigned b = 0; b < OUT_BYTES; b++) begin
         idx = 32'(beat) * OUT_BYTES + b;
         if (idx < RB) dout[8*b +: 8] = mem[8*idx +: 8];
      end
   end

endmodule

// File: rtl/pe_result_drain.sv
// Ping-pong capture of the cube result vector, streamed out as fixed-width
// beats over valid/ready so the cube can compute while the last result drains.
module pe_result_drain
   import pe_result_drain_pkg::*;
#(
   parameter int unsigned CUBE_NUM  = 3,
   parameter int unsigned BLOCK_NUM = 3,
   parameter int unsigned ARRAY_NUM = 3,
   parameter int unsigned OUT_BYTES = 4
) (
   input  logic                                            iClk,
   input  logic                                            iRst,
   input  logic                                            iCapture,
   input  logic [8*calc_rb(CUBE_NUM,BLOCK_NUM,ARRAY_NUM)-1:0] iResult,
   input  logic                                            iClearOverflow,
   output logic [8*OUT_BYTES-1:0]                          oData,
   output logic                                            oValid,
   input  logic                                            iReady,
   output logic                                            oLast,
   output logic [1:0]                                      oLevel,
   output logic                                            oOverflow
);

   localparam int unsigned RB    = calc_rb(CUBE_NUM, BLOCK_NUM, ARRAY_NUM);
   localparam int unsigned BEATS = calc_beats(RB, OUT_BYTES);
   localparam int unsigned BW    = beat_width(BEATS);

   logic [1:0]    full_q, full_d;
   logic          wptr_q, wptr_d;
   logic          rptr_q, rptr_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          ovf_q, ovf_d;

   logic          valid, xfer, rel, cap_ok, last_beat;
   logic [1:0]    bank_we;
   logic [8*OUT_BYTES-1:0] bank_data [2];

   for (genvar g = 0; g < 2; g++) begin : g_bank
      pe_drain_bank #(
         .RB        (RB),
         .OUT_BYTES (OUT_BYTES),
         .BW        (BW)
      ) u_bank (
         .clk  (iClk),
         .we   (bank_we[g]),
         .din  (iResult),
         .beat (beat_q),
         .dout (bank_data[g])
      );
   end

   always_comb begin
      last_beat = (beat_q == BW'(BEATS - 1));
      valid     = full_q[rptr_q];
      xfer      = valid & iReady;
      rel       = xfer & last_beat;
      // With both banks full the write bank is the one being drained; a
      // release on this edge frees it for the incoming capture.
      cap_ok    = iCapture & (~full_q[wptr_q] | (rel & (rptr_q == wptr_q)));

      full_d = full_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      beat_d = beat_q;
      ovf_d  = (ovf_q & ~iClearOverflow) | (iCapture & ~cap_ok);

      if (xfer) begin
         if (rel) begin
            beat_d         = '0;
            full_d[rptr_q] = 1'b0;
            rptr_d         = ~rptr_q;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
      if (cap_ok) begin
         full_d[wptr_q] = 1'b1;
         wptr_d         = ~wptr_q;
      end

      bank_we[0] = cap_ok & ~wptr_q;
      bank_we[1] = cap_ok & wptr_q;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         full_q <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         beat_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         beat_q <= beat_d;
         ovf_q  <= ovf_d;
      end
   end

   assign oValid    = valid;
   assign oData     = valid ? bank_data[rptr_q] : '0;
   assign oLast     = valid & last_beat;
   assign oLevel    = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   assign oOverflow = ovf_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Randomized and directed bench for pe_result_drain against a queue-based
// model of captured vectors.
module tb_pe_result_drain;

   localparam int unsigned RB    = 27;
   localparam int unsigned OB    = 4;
   localparam int unsigned BEATS = 7;

   logic              iClk = 1'b0;
   logic              iRst = 1'b0;
   logic              iCapture = 1'b0;
   logic [8*RB-1:0]   iResult = '0;
   logic              iClearOverflow = 1'b0;
   logic [8*OB-1:0]   oData;
   logic              oValid;
   logic              iReady = 1'b0;
   logic              oLast;
   logic [1:0]        oLevel;
   logic              oOverflow;

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   // Model: FIFO of accepted vectors (at most two), beat index of the head.
   logic [8*RB-1:0] vq [$];
   int unsigned     mbeat = 0;
   bit              movf  = 1'b0;

   pe_result_drain #(
      .CUBE_NUM  (3),
      .BLOCK_NUM (3),
      .ARRAY_NUM (3),
      .OUT_BYTES (OB)
   ) dut (
      .iClk           (iClk),
      .iRst           (iRst),
      .iCapture       (iCapture),
      .iResult        (iResult),
      .iClearOverflow (iClearOverflow),
      .oData          (oData),
      .oValid         (oValid),
      .iReady         (iReady),
      .oLast          (oLast),
      .oLevel         (oLevel),
      .oOverflow      (oOverflow)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_data();
      logic [31:0]     d;
      logic [8*RB-1:0] v;
      int unsigned     idx;
      d = '0;
      if (vq.size() != 0) begin
         v = vq[0];
         for (int unsigned b = 0; b < OB; b++) begin
            idx = mbeat * OB + b;
            if (idx < RB) d[8*b +: 8] = v[8*idx +: 8];
         end
      end
      return d;
   endfunction

   function automatic logic [8*RB-1:0] make_vec(input int base);
      logic [8*RB-1:0] v;
      for (int k = 0; k < RB; k++) v[8*k +: 8] = 8'(base + k);
      return v;
   endfunction

   function automatic logic [8*RB-1:0] rand_vec();
      logic [8*RB-1:0] v;
      for (int k = 0; k < RB; k++) v[8*k +: 8] = 8'($urandom);
      return v;
   endfunction

   // Model update: a transfer happens when a vector is pending and iReady is high.
   initial begin
      forever begin
         @(posedge iClk or posedge iRst);
         if (iRst) begin
            vq.delete();
            mbeat = 0;
            movf  = 1'b0;
         end else begin
            int  sz;
            bit  xfer, rel, drop;
            sz   = vq.size();
            xfer = (sz != 0) && iReady;
            rel  = xfer && (mbeat == BEATS - 1);
            drop = iCapture && !(sz < 2 || rel);
            if (xfer) begin
               if (rel) begin
                  void'(vq.pop_front());
                  mbeat = 0;
               end else begin
                  mbeat++;
               end
            end
            if (iCapture && !drop) vq.push_back(iResult);
            movf = (movf && !iClearOverflow) || drop;
         end
      end
   end

   // Compare every cycle on the falling edge.
   initial begin
      forever begin
         @(negedge iClk);
         if (run) begin
            check("valid", 32'(oValid), 32'(vq.size() != 0));
            check("last", 32'(oLast), 32'((vq.size() != 0) && (mbeat == BEATS - 1)));
            check("level", 32'(oLevel), 32'(vq.size()));
            check("overflow", 32'(oOverflow), 32'(movf));
            check("data", oData, model_data());
         end
      end
   end

   task automatic tick();
      @(negedge iClk);
      #1;
   endtask

   task automatic capture(input logic [8*RB-1:0] v);
      iCapture = 1'b1;
      iResult  = v;
      tick();
      iCapture = 1'b0;
   endtask

   task automatic wait_last(input string name);
      int n;
      n = 0;
      while (!(oValid && oLast) && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL %s: oLast not seen within 40 cycles", name);
      end
   endtask

   task automatic drain();
      iReady = 1'b1;
      for (int i = 0; i < 2 * BEATS + 4; i++) tick();
   endtask

   task automatic do_reset();
      iRst = 1'b1;
      tick();
      tick();
      iRst = 1'b0;
   endtask

   initial begin
      #2;
      iRst = 1'b1;
      tick();
      check("reset_valid", 32'(oValid), 32'd0);
      check("reset_level", 32'(oLevel), 32'd0);
      check("reset_data", oData, 32'd0);
      tick();
      iRst = 1'b0;
      run  = 1'b1;

      // 1: single vector, consumer always ready
      iReady = 1'b1;
      capture(make_vec(1));
      check("t1_beat0", oData, 32'h04030201);
      check("t1_level", 32'(oLevel), 32'd1);
      wait_last("t1");
      check("t1_lastdata", oData, 32'h001B1A19);
      tick();
      check("t1_done_valid", 32'(oValid), 32'd0);
      check("t1_done_level", 32'(oLevel), 32'd0);

      // 2: stalls every other cycle
      iReady = 1'b0;
      capture(make_vec(8'h40));
      for (int i = 0; i < 2 * BEATS + 2; i++) begin
         iReady = (i % 2 == 0);
         tick();
      end
      drain();

      // 3: two captures two cycles apart, back-to-back drain
      iReady = 1'b1;
      capture(make_vec(8'h60));
      tick();
      capture(make_vec(8'h90));
      check("t3_level2", 32'(oLevel), 32'd2);
      drain();

      // 4: overflow while stalled
      iReady = 1'b0;
      capture(make_vec(8'h10));
      capture(make_vec(8'h30));
      capture(make_vec(8'h50));
      check("t4_level", 32'(oLevel), 32'd2);
      check("t4_ovf", 32'(oOverflow), 32'd1);
      iClearOverflow = 1'b1;
      tick();
      iClearOverflow = 1'b0;
      check("t4_ovf_clr", 32'(oOverflow), 32'd0);
      drain();

      // 5: capture on the same edge as the head's last-beat release
      iReady = 1'b0;
      capture(make_vec(8'h21));
      capture(make_vec(8'h41));
      iReady = 1'b1;
      wait_last("t5");
      capture(make_vec(8'h81));
      check("t5_ovf", 32'(oOverflow), 32'd0);
      check("t5_level", 32'(oLevel), 32'd2);
      check("t5_b_beat0", oData, 32'h44434241);
      drain();

      // 6: reset mid-vector
      capture(make_vec(8'hA0));
      tick();
      tick();
      tick();
      iRst = 1'b1;
      #1;
      check("t6_valid", 32'(oValid), 32'd0);
      check("t6_last", 32'(oLast), 32'd0);
      check("t6_data", oData, 32'd0);
      check("t6_level", 32'(oLevel), 32'd0);
      tick();
      iRst = 1'b0;
      capture(make_vec(8'hC0));
      check("t6_restart", oData, 32'hC3C2C1C0);
      drain();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         iReady         = ($urandom_range(0, 3) != 0);
         iCapture       = ($urandom_range(0, 5) == 0);
         iResult        = rand_vec();
         iClearOverflow = ($urandom_range(0, 30) == 0);
         iRst           = ($urandom_range(0, 200) == 0);
         tick();
      end
      iCapture       = 1'b0;
      iClearOverflow = 1'b0;
      iRst           = 1'b0;
      drain();

      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
